// File: rtl/vga_frame_crc.sv
// ---------------------------------------------------------------------------
// vga_frame_crc
//
// Watches the VGA pixel/sync stream produced by the video block and computes
// a per-frame signature. Between two vsync assertion edges every sampled
// pixel ({r,g,b}, 12 bits) is folded into a reflected CRC-32. Lines (hsync
// edges), pixels and the length of the most recent line are counted. At
// frame end the results are latched into bus-visible registers. A small
// Wishbone pipelined slave controls capture and reads the results.
//
// Ports
//   clk, rst_n                  system clock, asynchronous active-low reset
//   vga_r/g/b [3:0]             pixel colour
//   vga_hsync, vga_vsync        syncs; active level set by HSYNC_POL/VSYNC_POL
//   pix_valid                   pixel sample strobe
//   wb_adr [2:0]                word index into the register map
//   wb_dat_w [31:0]             write data
//   wb_dat_r [31:0]             read data, valid with wb_ack
//   wb_sel [3:0]                byte selects (only byte 0 of CTRL is writable)
//   wb_cyc, wb_stb, wb_we       bus request
//   wb_ack, wb_stall, wb_err    bus response (stall and err are always 0)
//
// Register map (word index / byte offset)
//   0 / 0x00 CTRL     W: [0] START, [1] CONTINUOUS, [2] ABORT; R: [1] CONTINUOUS
//   1 / 0x04 STATUS   [1:0] state, [2] done, [3] overflow
//   2 / 0x08 CRC      latched ~crc of the last completed frame
//   3 / 0x0C PIXCNT   latched pixel count
//   4 / 0x10 LINES    {lines[31:16], line length[15:0]}
//   5 / 0x14 FRAMECNT completed frames (wraps)
//   6,7               read 0, writes ignored
// ---------------------------------------------------------------------------
module vga_frame_crc #(
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        pix_valid,
    input  logic [2:0]  wb_adr,
    input  logic [31:0] wb_dat_w,
    output logic [31:0] wb_dat_r,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic        wb_ack,
    output logic        wb_stall,
    output logic        wb_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t      r_state;
    logic        r_hs_d;
    logic        r_vs_d;
    logic        r_cont;
    logic        r_done;
    logic        r_ovf;
    logic [31:0] r_crc;
    logic [31:0] r_pix_cnt;
    logic [15:0] r_line_cnt;
    logic [15:0] r_line_len;
    logic [15:0] r_run_len;
    logic [31:0] r_crc_lat;
    logic [31:0] r_pix_lat;
    logic [15:0] r_lines_lat;
    logic [15:0] r_linelen_lat;
    logic [31:0] r_frame_cnt;
    logic        r_ack;
    logic [31:0] r_dat_r;

    // -----------------------------------------------------------------------
    // Sync edge detection: an assertion edge is "previously inactive, now
    // active", with the active level chosen by the polarity parameter.
    // -----------------------------------------------------------------------
    logic w_hs_act;
    logic w_vs_act;
    logic w_hs_edge;
    logic w_vs_edge;

    assign w_hs_act  = (vga_hsync == HSYNC_POL);
    assign w_vs_act  = (vga_vsync == VSYNC_POL);
    assign w_hs_edge = w_hs_act && (r_hs_d != HSYNC_POL);
    assign w_vs_edge = w_vs_act && (r_vs_d != VSYNC_POL);

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic w_req;
    logic w_ctrl_wr;
    logic w_start;
    logic w_abort;

    assign w_req     = wb_cyc && wb_stb;
    assign w_ctrl_wr = w_req && wb_we && (wb_adr == 3'd0) && wb_sel[0];
    assign w_start   = w_ctrl_wr && wb_dat_w[0];
    assign w_abort   = w_ctrl_wr && wb_dat_w[2];

    // -----------------------------------------------------------------------
    // CRC: 12 bit-serial steps of the reflected CRC-32, pixel bit 0 first.
    // -----------------------------------------------------------------------
    logic [11:0] w_pix_data;
    logic [31:0] w_crc_next;

    assign w_pix_data = {vga_r, vga_g, vga_b};

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_crc
            logic [31:0] w_in;
            logic [31:0] w_out;
            if (gi == 0) begin : g_first
                assign w_in = r_crc;
            end else begin : g_rest
                assign w_in = g_crc[gi-1].w_out;
            end
            assign w_out = (w_in >> 1) ^ ((w_in[0] ^ w_pix_data[gi]) ? CRC_POLY : 32'h0);
        end
    endgenerate

    assign w_crc_next = g_crc[11].w_out;

    // -----------------------------------------------------------------------
    // Saturating counter next values
    // -----------------------------------------------------------------------
    logic        w_pix_sat;
    logic        w_line_sat;
    logic        w_run_sat;
    logic [31:0] w_pix_inc;
    logic [15:0] w_line_inc;
    logic [15:0] w_run_inc;

    assign w_pix_sat  = (r_pix_cnt == 32'hFFFF_FFFF);
    assign w_line_sat = (r_line_cnt == 16'hFFFF);
    assign w_run_sat  = (r_run_len == 16'hFFFF);
    assign w_pix_inc  = w_pix_sat  ? r_pix_cnt  : r_pix_cnt + 32'd1;
    assign w_line_inc = w_line_sat ? r_line_cnt : r_line_cnt + 16'd1;
    assign w_run_inc  = w_run_sat  ? r_run_len  : r_run_len + 16'd1;

    // -----------------------------------------------------------------------
    // FSM next state and datapath strobes
    // -----------------------------------------------------------------------
    state_t w_state_next;
    logic   w_clear;   // START accepted: clear done/overflow
    logic   w_init;    // first vsync edge after arming
    logic   w_pix;     // sample this pixel
    logic   w_line;    // hsync edge during capture
    logic   w_frame;   // vsync edge during capture

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_init       = 1'b0;
        w_pix        = 1'b0;
        w_line       = 1'b0;
        w_frame      = 1'b0;
        if (w_abort) begin
            // ABORT wins over everything, including a START in the same write
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        w_state_next = ST_ARM;
                        w_clear      = 1'b1;
                    end
                end
                ST_ARM: begin
                    if (w_vs_edge) begin
                        w_state_next = ST_CAPTURE;
                        w_init       = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    w_pix  = pix_valid && !w_hs_act && !w_vs_act;
                    w_line = w_hs_edge;
                    if (w_vs_edge) begin
                        w_frame      = 1'b1;
                        w_state_next = r_cont ? ST_CAPTURE : ST_DONE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Line update is applied before the frame latch, so a simultaneous
    // hsync+vsync edge latches the already-incremented line values.
    logic [15:0] w_lines_upd;
    logic [15:0] w_linelen_upd;
    logic        w_reinit;

    assign w_lines_upd   = w_line ? w_line_inc : r_line_cnt;
    assign w_linelen_upd = w_line ? r_run_len  : r_line_len;
    assign w_reinit      = w_init || (w_frame && r_cont);

    // -----------------------------------------------------------------------
    // Register read mux
    // -----------------------------------------------------------------------
    logic [31:0] w_rd_data;

    always_comb begin
        w_rd_data = 32'h0;
        case (wb_adr)
            3'd0:    w_rd_data = {30'h0, r_cont, 1'b0};
            3'd1:    w_rd_data = {28'h0, r_ovf, r_done, r_state};
            3'd2:    w_rd_data = r_crc_lat;
            3'd3:    w_rd_data = r_pix_lat;
            3'd4:    w_rd_data = {r_lines_lat, r_linelen_lat};
            3'd5:    w_rd_data = r_frame_cnt;
            default: w_rd_data = 32'h0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            // Reset the delayed syncs to the active level so that no edge
            // can be seen on the first cycle after reset.
            r_hs_d        <= HSYNC_POL;
            r_vs_d        <= VSYNC_POL;
            r_cont        <= 1'b0;
            r_done        <= 1'b0;
            r_ovf         <= 1'b0;
            r_crc         <= CRC_INIT;
            r_pix_cnt     <= 32'h0;
            r_line_cnt    <= 16'h0;
            r_line_len    <= 16'h0;
            r_run_len     <= 16'h0;
            r_crc_lat     <= 32'h0;
            r_pix_lat     <= 32'h0;
            r_lines_lat   <= 16'h0;
            r_linelen_lat <= 16'h0;
            r_frame_cnt   <= 32'h0;
            r_ack         <= 1'b0;
            r_dat_r       <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_hs_d  <= vga_hsync;
            r_vs_d  <= vga_vsync;

            if (w_ctrl_wr) begin
                r_cont <= wb_dat_w[1];
            end

            if (w_clear) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end else if ((w_pix && (w_pix_sat || w_run_sat)) || (w_line && w_line_sat)) begin
                r_ovf <= 1'b1;
            end

            if (w_reinit) begin
                r_crc      <= CRC_INIT;
                r_pix_cnt  <= 32'h0;
                r_line_cnt <= 16'h0;
                r_line_len <= 16'h0;
                r_run_len  <= 16'h0;
            end else begin
                if (w_pix) begin
                    r_crc     <= w_crc_next;
                    r_pix_cnt <= w_pix_inc;
                    r_run_len <= w_run_inc;
                end
                if (w_line) begin
                    r_line_cnt <= w_line_inc;
                    r_line_len <= r_run_len;
                    r_run_len  <= 16'h0;
                end
            end

            if (w_frame) begin
                r_crc_lat     <= ~r_crc;
                r_pix_lat     <= r_pix_cnt;
                r_lines_lat   <= w_lines_upd;
                r_linelen_lat <= w_linelen_upd;
                r_frame_cnt   <= r_frame_cnt + 32'd1;
                r_done        <= 1'b1;
            end

            r_ack <= w_req;
            if (w_req && !wb_we) begin
                r_dat_r <= w_rd_data;
            end
        end
    end

    // An ack is only presented while the master still holds the cycle.
    assign wb_ack   = r_ack && wb_cyc;
    assign wb_dat_r = r_dat_r;
    assign wb_stall = 1'b0;
    assign wb_err   = 1'b0;

    // Bits with no function in the register map.
    logic w_unused;
    assign w_unused = &{1'b0, wb_sel[3:1], wb_dat_w[31:3]};

endmodule
